pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/diaosi_types_pkg.sv | 38 +++
 rtl/hazard_detect.sv | 24 ++
 rtl/pipeline_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/diaosi_types_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and the bundle
// of stage-latch enable/flush controls.
package diaosi_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DWAIT = 2'b01,
    HALT  = 2'b10
  } pctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_dc_en;
    logic if_dc_flush;
    logic dc_ex_en;
    logic dc_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic mem_wb_en;
  } pctrl_ctl_t;

  // Every enable set to en and every flush set to fl.
  function automatic pctrl_ctl_t ctl_uniform(input logic en, input logic fl);
    pctrl_ctl_t c;
    c.pc_en        = en;
    c.if_dc_en     = en;
    c.if_dc_flush  = fl;
    c.dc_ex_en     = en;
    c.dc_ex_flush  = fl;
    c.ex_mem_en    = en;
    c.ex_mem_flush = fl;
    c.mem_wb_en    = en;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds an
// instruction currently in decode.
module hazard_detect
  import diaosi_types_pkg::*;
(
  input  logic             ex_dren,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] dc_rs,
  input  logic [REG_W-1:0] dc_rt,
  input  logic             dc_uses_rt,
  output logic             loaduse
);

  logic dest_live_s;
  logic rs_match_s;
  logic rt_match_s;

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign dest_live_s = ex_dren & (ex_wsel != {REG_W{1'b0}});
  assign rs_match_s  = (ex_wsel == dc_rs);
  assign rt_match_s  = dc_uses_rt & (ex_wsel == dc_rt);
  assign loaduse     = dest_live_s & (rs_match_s | rt_match_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush controller with RUN/DWAIT/HALT FSM.
// Optional saturating performance counters enabled by macro PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import diaosi_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_halt,
  input  logic             mem_redirect,
  input  logic             ex_dren,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] dc_rs,
  input  logic [REG_W-1:0] dc_rt,
  input  logic             dc_uses_rt,
  output logic             pc_en,
  output logic             if_dc_en,
  output logic             if_dc_flush,
  output logic             dc_ex_en,
  output logic             dc_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pctrl_state_t state_q;
  pctrl_state_t state_d;
  pctrl_ctl_t   ctl_s;
  logic         dstall_s;
  logic         loaduse_s;
  logic         active_s;

  hazard_detect u_hazard (
    .ex_dren    (ex_dren),
    .ex_wsel    (ex_wsel),
    .dc_rs      (dc_rs),
    .dc_rt      (dc_rt),
    .dc_uses_rt (dc_uses_rt),
    .loaduse    (loaduse_s)
  );

  assign dstall_s = (mem_dren | mem_dwen) & ~dhit;
  assign active_s = ~RST & ((state_q == RUN) | (state_q == DWAIT));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and latch controls, highest-priority hazard first.
  always_comb begin
    state_d = state_q;
    ctl_s   = ctl_uniform(1'b1, 1'b0);
    if (RST) begin
      state_d = RUN;
      ctl_s   = ctl_uniform(1'b0, 1'b1);
    end else begin
      case (state_q)
        HALT: begin
          state_d = HALT;
          ctl_s   = ctl_uniform(1'b0, 1'b0);
        end
        RUN, DWAIT: begin
          if (dstall_s) begin
            state_d = DWAIT;
            ctl_s   = ctl_uniform(1'b0, 1'b0);
          end else if (mem_halt) begin
            // Let the halting instruction retire into WB, freeze everything else.
            state_d         = HALT;
            ctl_s           = ctl_uniform(1'b0, 1'b0);
            ctl_s.mem_wb_en = 1'b1;
          end else if (mem_redirect) begin
            state_d = RUN;
            ctl_s   = ctl_uniform(1'b1, 1'b1);
          end else if (loaduse_s) begin
            state_d           = RUN;
            ctl_s             = ctl_uniform(1'b1, 1'b0);
            ctl_s.pc_en       = 1'b0;
            ctl_s.if_dc_en    = 1'b0;
            ctl_s.dc_ex_flush = 1'b1;
          end else if (!ihit) begin
            state_d           = RUN;
            ctl_s             = ctl_uniform(1'b1, 1'b0);
            ctl_s.pc_en       = 1'b0;
            ctl_s.if_dc_flush = 1'b1;
          end else begin
            state_d = RUN;
            ctl_s   = ctl_uniform(1'b1, 1'b0);
          end
        end
        default: begin
          // Unreachable encoding: freeze for this cycle and recover to RUN.
          state_d = RUN;
          ctl_s   = ctl_uniform(1'b0, 1'b0);
        end
      endcase
    end
  end

  assign pc_en        = ctl_s.pc_en;
  assign if_dc_en     = ctl_s.if_dc_en;
  assign if_dc_flush  = ctl_s.if_dc_flush;
  assign dc_ex_en     = ctl_s.dc_ex_en;
  assign dc_ex_flush  = ctl_s.dc_ex_flush;
  assign ex_mem_en    = ctl_s.ex_mem_en;
  assign ex_mem_flush = ctl_s.ex_mem_flush;
  assign mem_wb_en    = ctl_s.mem_wb_en;
  assign halted       = ~RST & (state_q == HALT);

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;
  logic             stall_inc_s;
  logic             flush_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  assign stall_inc_s = active_s & ~ctl_s.pc_en;
  assign flush_inc_s = active_s & ~dstall_s & ~mem_halt & mem_redirect;

  // Saturating next values for both counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc_s) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_inc_s) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_active_s;
  assign unused_active_s = active_s;
  assign stall_cnt       = {CNT_W{1'b0}};
  assign flush_cnt       = {CNT_W{1'b0}};
`endif

endmodule
